// File: rtl/seg_pkg.sv
// Shared types and helpers for the scanned 7-segment counter: glyph table,
// blank pattern and the binary-to-BCD converter state encoding.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  // Active-low {dp,g,f,e,d,c,b,a}; dp stays off, out-of-range nibbles go dark.
  function automatic logic [7:0] seg_glyph(input logic [3:0] nib);
    case (nib)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with start/busy/done handshake.
// Requests that arrive while busy are remembered and rerun with the latest input.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BITS_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  conv_state_t         state, state_next;
  logic                pend;
  logic [BIN_W-1:0]    shreg;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] adj;
  logic [BITS_W-1:0]   bit_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (bit_cnt == BITS_W'(BIN_W - 1)) state_next = DONE;
      DONE:    state_next = (pend || start) ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // A start seen in DONE is treated like a pending request so it is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      scratch <= '0;
      bit_cnt <= '0;
      pend    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          scratch <= {adj[4*DIGITS-2:0], shreg[BIN_W-1]};
          shreg   <= {shreg[BIN_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (start) pend <= 1'b1;
        end
        DONE: begin
          if (pend || start) begin
            shreg   <= bin;
            scratch <= '0;
            bit_cnt <= '0;
            pend    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign bcd  = scratch;

endmodule

// File: rtl/seg_scan_counter.sv
// Free-running decimal counter driving a multiplexed common-anode 7-segment display.
// Define SEG_LZ_BLANK_EN to blank leading zeros on digits above digit 0.
module seg_scan_counter
  import seg_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DIGITS      = 6,
  parameter int TICK_HZ     = 10,
  parameter int SCAN_HZ     = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        seg_dig
);

  localparam int CNT_W    = $clog2(10**DIGITS);
  localparam int MAXV     = 10**DIGITS - 1;
  localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_FREQ_HZ / SCAN_HZ;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic [CNT_W-1:0]    value;
  logic                req_q;
  logic                conv_busy;
  logic                conv_done;
  logic [4*DIGITS-1:0] conv_bcd;
  logic [4*DIGITS-1:0] disp_bcd;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]    dig_idx;
  logic [IDX_W-1:0]    next_idx;
  logic [DIGITS-1:0]   lz_blank;
  logic [7:0]          next_glyph;

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  // req_q starts high so the display is refreshed once coming out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      value    <= '0;
      req_q    <= 1'b1;
    end else begin
      req_q <= 1'b0;
      if (clr) begin
        tick_cnt <= '0;
        value    <= '0;
        req_q    <= 1'b1;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick && en) begin
          value <= (value == CNT_W'(MAXV)) ? '0 : value + 1'b1;
          req_q <= 1'b1;
        end
      end
    end
  end

  bin2bcd_seq #(
    .BIN_W  (CNT_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (req_q),
    .bin   (value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  conv_done_while_busy: assert property (@(posedge clk) disable iff (!rst) conv_done |-> conv_busy);

  // Whole-word load so the scan never sees a half-updated number.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           disp_bcd <= '0;
    else if (conv_done) disp_bcd <= conv_bcd;
  end

`ifdef SEG_LZ_BLANK_EN
  logic zero_run;
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run    = zero_run && (disp_bcd[4*k +: 4] == 4'd0);
      lz_blank[k] = zero_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign next_idx   = (dig_idx == IDX_W'(DIGITS - 1)) ? '0 : dig_idx + 1'b1;
  assign next_glyph = lz_blank[next_idx] ? SEG_BLANK : seg_glyph(disp_bcd[4*next_idx +: 4]);

  // sel and seg_dig are loaded together from the upcoming index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
      sel      <= DIGITS'(1);
      seg_dig  <= SEG_BLANK;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      dig_idx  <= next_idx;
      sel      <= DIGITS'(1) << next_idx;
      seg_dig  <= next_glyph;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_counter.sv
// Randomized, model-checked bench for seg_scan_counter (2 digits, tick every
// 10 clk, 2 clk dwell per digit); honours SEG_LZ_BLANK_EN when defined.
module tb_seg_scan_counter;

  localparam int CLK_FREQ_HZ = 1000;
  localparam int TICK_HZ     = 100;
  localparam int SCAN_HZ     = 500;
  localparam int DIGITS      = 2;
  localparam int TICK_DIV    = CLK_FREQ_HZ / TICK_HZ;
  localparam int MODV        = 10**DIGITS;
  localparam int CNT_W       = $clog2(MODV);
  localparam int LAT         = CNT_W + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en  = 1'b0;
  logic              clr = 1'b0;
  logic [DIGITS-1:0] sel;
  logic [7:0]        seg_dig;

  int tests_run    = 0;
  int tests_failed = 0;

  int m_value;
  int m_phase;

  logic [7:0] glyph_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  always #5 clk = ~clk;

  seg_scan_counter #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .DIGITS      (DIGITS),
    .TICK_HZ     (TICK_HZ),
    .SCAN_HZ     (SCAN_HZ)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .sel     (sel),
    .seg_dig (seg_dig)
  );

  // Counter behaviour in plain arithmetic: a tick every TICK_DIV clocks since reset/clr.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_value <= 0;
      m_phase <= 0;
    end else if (clr) begin
      m_value <= 0;
      m_phase <= 0;
    end else if (m_phase == TICK_DIV - 1) begin
      m_phase <= 0;
      if (en) m_value <= (m_value + 1) % MODV;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  function automatic logic [7:0] exp_glyph(int v, int k);
    int d;
    d = (v / (10**k)) % 10;
`ifdef SEG_LZ_BLANK_EN
    if (k > 0 && v < 10**k) return 8'hFF;
`endif
    return glyph_tab[d];
  endfunction

  function automatic logic [7:0] to_bcd(int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic observe_digits(output logic [7:0] g0, output logic [7:0] g1, output bit ok);
    bit got0;
    bit got1;
    got0 = 1'b0;
    got1 = 1'b0;
    g0 = 8'h00;
    g1 = 8'h00;
    for (int i = 0; i < 20 && !(got0 && got1); i++) begin
      @(negedge clk);
      if (sel == 2'b01 && !got0) begin
        g0 = seg_dig;
        got0 = 1'b1;
      end else if (sel == 2'b10 && !got1) begin
        g1 = seg_dig;
        got1 = 1'b1;
      end
    end
    ok = got0 && got1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    bit found;
    rst = 1'b0;
    en  = 1'b0;
    clr = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (sel !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL reset_sel: got %b expected 01", sel);
    end
    tests_run++;
    if (seg_dig !== 8'hFF) begin
      tests_failed++;
      $display("[TB] FAIL reset_seg: got %h expected FF", seg_dig);
    end
    rst = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (sel == 2'b01 && seg_dig == 8'hC0) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_digit0: got sel=%b seg=%h expected digit0 C0 within 10 clk", sel, seg_dig);
    end
  endtask

  task automatic test_count();
    bit reached;
    bit ok;
    logic [7:0] g0, g1;
    pulse_clr();
    en = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk);
      if (m_value == 10) reached = 1'b1;
    end
    en = 1'b0;
    tests_run++;
    if (!reached) begin
      tests_failed++;
      $display("[TB] FAIL count_reach10: got model value %0d expected 10 within bound", m_value);
    end
    repeat (LAT - 1) @(negedge clk);
    tests_run++;
    if (dut.disp_bcd !== to_bcd(9)) begin
      tests_failed++;
      $display("[TB] FAIL count_latency_early: got %h expected %h", dut.disp_bcd, to_bcd(9));
    end
    @(negedge clk);
    tests_run++;
    if (dut.disp_bcd !== to_bcd(10)) begin
      tests_failed++;
      $display("[TB] FAIL count_latency_update: got %h expected %h", dut.disp_bcd, to_bcd(10));
    end
    repeat (20) @(negedge clk);
    observe_digits(g0, g1, ok);
    tests_run++;
    if (!ok || g0 !== exp_glyph(10, 0)) begin
      tests_failed++;
      $display("[TB] FAIL count_digit0: got %h expected %h", g0, exp_glyph(10, 0));
    end
    tests_run++;
    if (!ok || g1 !== exp_glyph(10, 1)) begin
      tests_failed++;
      $display("[TB] FAIL count_digit1: got %h expected %h", g1, exp_glyph(10, 1));
    end
  endtask

  task automatic test_wrap();
    bit reached;
    bit ok;
    logic [7:0] g0, g1;
    en = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 1200 && !reached; i++) begin
      @(negedge clk);
      if (m_value == MODV - 1) reached = 1'b1;
    end
    for (int i = 0; i < 20 && reached && m_value != 0; i++) @(negedge clk);
    en = 1'b0;
    tests_run++;
    if (!reached || m_value != 0) begin
      tests_failed++;
      $display("[TB] FAIL wrap_reach: got model value %0d expected 0 after 99", m_value);
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (dut.disp_bcd !== to_bcd(0)) begin
      tests_failed++;
      $display("[TB] FAIL wrap_display: got %h expected 00", dut.disp_bcd);
    end
    observe_digits(g0, g1, ok);
    tests_run++;
    if (!ok || g0 !== 8'hC0) begin
      tests_failed++;
      $display("[TB] FAIL wrap_digit0: got %h expected C0", g0);
    end
    tests_run++;
    if (!ok || g1 !== exp_glyph(0, 1)) begin
      tests_failed++;
      $display("[TB] FAIL wrap_digit1: got %h expected %h", g1, exp_glyph(0, 1));
    end
  endtask

  task automatic test_scan();
    logic [1:0] prev;
    logic [1:0] cur;
    logic [1:0] want;
    int len;
    bit changed;
    prev = sel;
    changed = 1'b0;
    for (int i = 0; i < 10 && !changed; i++) begin
      @(negedge clk);
      if (sel != prev) changed = 1'b1;
    end
    want = sel;
    for (int run = 0; run < 8; run++) begin
      cur = sel;
      len = 1;
      changed = 1'b0;
      for (int i = 0; i < 10 && !changed; i++) begin
        @(negedge clk);
        if (sel == cur) len++;
        else changed = 1'b1;
      end
      tests_run++;
      if (cur !== want || len != 2 || !changed) begin
        tests_failed++;
        $display("[TB] FAIL scan_run%0d: got sel=%b len=%0d expected sel=%b len=2", run, cur, len, want);
      end
      want = (want == 2'b01) ? 2'b10 : 2'b01;
    end
  endtask

  task automatic test_clr_during_shift();
    bit reached;
    bit pend_seen;
    bit ok;
    int torn;
    logic [7:0] d;
    logic [7:0] g0, g1;
    pulse_clr();
    en = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 700 && !reached; i++) begin
      @(negedge clk);
      if (m_value == 58) reached = 1'b1;
    end
    en = 1'b0;
    tests_run++;
    if (!reached) begin
      tests_failed++;
      $display("[TB] FAIL clr_reach58: got model value %0d expected 58", m_value);
    end
    torn = 0;
    pend_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      d = dut.disp_bcd;
      if (d !== to_bcd(57) && d !== to_bcd(58) && d !== to_bcd(0)) torn++;
      if (dut.u_conv.pend === 1'b1) pend_seen = 1'b1;
      if (i == 3) clr = 1'b1;
      if (i == 4) clr = 1'b0;
      @(negedge clk);
    end
    tests_run++;
    if (!pend_seen) begin
      tests_failed++;
      $display("[TB] FAIL clr_pend: got pend never set expected set");
    end
    tests_run++;
    if (torn != 0) begin
      tests_failed++;
      $display("[TB] FAIL clr_torn: got %0d torn cycles expected 0", torn);
    end
    tests_run++;
    if (dut.disp_bcd !== to_bcd(m_value) || m_value != 0) begin
      tests_failed++;
      $display("[TB] FAIL clr_final: got %h expected %h", dut.disp_bcd, to_bcd(0));
    end
    repeat (5) @(negedge clk);
    observe_digits(g0, g1, ok);
    tests_run++;
    if (!ok || g0 !== 8'hC0 || g1 !== exp_glyph(0, 1)) begin
      tests_failed++;
      $display("[TB] FAIL clr_digits: got %h %h expected C0 %h", g1, g0, exp_glyph(0, 1));
    end
  endtask

  task automatic test_enable_hold();
    int v;
    bit reached;
    en = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge clk);
      if (m_value == 3) reached = 1'b1;
    end
    en = 1'b0;
    v = m_value;
    repeat (5 * TICK_DIV) @(negedge clk);
    tests_run++;
    if (!reached || dut.value !== CNT_W'(v)) begin
      tests_failed++;
      $display("[TB] FAIL hold_value: got %0d expected %0d", dut.value, v);
    end
    tests_run++;
    if (dut.disp_bcd !== to_bcd(v)) begin
      tests_failed++;
      $display("[TB] FAIL hold_display: got %h expected %h", dut.disp_bcd, to_bcd(v));
    end
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (m_phase == TICK_DIV - 1) reached = 1'b1;
      else @(negedge clk);
    end
    clr = 1'b1;
    en  = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    en  = 1'b0;
    tests_run++;
    if (!reached || dut.value !== CNT_W'(0)) begin
      tests_failed++;
      $display("[TB] FAIL clr_en_value: got %0d expected 0", dut.value);
    end
    tests_run++;
    if (dut.tick_cnt !== '0) begin
      tests_failed++;
      $display("[TB] FAIL clr_en_prescaler: got %0d expected 0", dut.tick_cnt);
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (dut.value !== CNT_W'(m_value) || dut.disp_bcd !== to_bcd(0)) begin
      tests_failed++;
      $display("[TB] FAIL clr_en_settle: got value=%0d disp=%h expected 0 00", dut.value, dut.disp_bcd);
    end
  endtask

  task automatic test_random();
    int n;
    bit ok;
    logic [7:0] g0, g1;
    for (int round = 0; round < 8; round++) begin
      n = $urandom_range(30, 150);
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        en  = ($urandom_range(0, 3) != 0);
        clr = ($urandom_range(0, 24) == 0);
      end
      @(negedge clk);
      en  = 1'b0;
      clr = 1'b0;
      repeat (20) @(negedge clk);
      tests_run++;
      if (dut.disp_bcd !== to_bcd(m_value)) begin
        tests_failed++;
        $display("[TB] FAIL random%0d_display: got %h expected %h", round, dut.disp_bcd, to_bcd(m_value));
      end
      observe_digits(g0, g1, ok);
      tests_run++;
      if (!ok || g0 !== exp_glyph(m_value, 0)) begin
        tests_failed++;
        $display("[TB] FAIL random%0d_digit0: got %h expected %h", round, g0, exp_glyph(m_value, 0));
      end
      tests_run++;
      if (!ok || g1 !== exp_glyph(m_value, 1)) begin
        tests_failed++;
        $display("[TB] FAIL random%0d_digit1: got %h expected %h", round, g1, exp_glyph(m_value, 1));
      end
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    repeat (37) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (sel !== 2'b01 || seg_dig !== 8'hFF || dut.value !== CNT_W'(0) || dut.disp_bcd !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got sel=%b seg=%h value=%0d disp=%h expected 01 FF 0 00",
               sel, seg_dig, dut.value, dut.disp_bcd);
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_count();
    test_scan();
    test_wrap();
    test_clr_during_shift();
    test_enable_hold();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
